dmem_sized_port: RTL and testbench
==================================

// Module: dmem_sized_port
// PURPOSE
//  Parametrised byte-addressable data memory behind a single req/done handshake.
//  Supports word/half/byte stores and loads, sign/zero extension and fixed programmable latency.
//  Flags misaligned and out-of-range accesses instead of corrupting memory.
//  Sits between the MEM stage of the CPU core and its data store.
// PARAMETERS
//  DEPTH_BYTES  1024  memory size in bytes; power of two, >=8
//  READ_LAT     1     accept-to-done latency in cycles; legal 1..4
//  BIG_ENDIAN   1     1: lowest address holds MSB of the slice; 0: holds LSB
// PORTS
//  clk_i       in   1   clock, all state on rising edge
//  rst_i       in   1   asynchronous reset, active low
//  req_i       in   1   request valid
//  we_i        in   1   1 = store, 0 = load
//  size_i      in   2   11 word, 10 half, 01 byte, 00 illegal
//  unsigned_i  in   1   load extension: 1 zero-extend, 0 sign-extend
//  addr_i      in   32  byte address
//  wdata_i     in   32  store data; half uses [15:0], byte uses [7:0]
//  ready_o     out  1   block can accept a request this cycle
//  done_o      out  1   one-cycle completion pulse (loads and stores)
//  err_o       out  1   valid with done_o: access rejected
//  rdata_o     out  32  load result, valid with done_o, held until next done_o
// BEHAVIOUR
//  Reset (rst_i low, any time): state IDLE, ready_o=1, done_o=0, err_o=0, rdata_o=0.
//  Memory contents are not cleared by reset.
//  Accept: on rising edge with req_i & ready_o (cycle k); all inputs sampled only then.
//   Inputs are ignored while ready_o=0.
//  Error check at accept, any one -> error:
//   size_i=00; half with addr[0]=1; word with addr[1:0]!=0;
//   addr_i + nbytes > DEPTH_BYTES (nbytes = 4/2/1); use >=33-bit compare, no wrap.
//  Store, no error: bytes written at the accept edge; errored store writes nothing.
//  Load, no error: bytes read at the accept edge into a hold register.
//   Extend per unsigned_i; word ignores unsigned_i.
//   Errored load returns rdata_o=0.
//  Byte order: BIG_ENDIAN=1 -> Mem[a]=slice MSB ... Mem[a+n-1]=slice LSB;
//   BIG_ENDIAN=0 reversed; loads use the same order as stores.
//  FSM: IDLE -accept-> (READ_LAT==1 ? RESP : WAIT); WAIT counts READ_LAT-1 cycles -> RESP;
//   RESP -> IDLE unconditionally.
//  ready_o=1 only in IDLE; done_o=1 only in RESP (cycle k+READ_LAT).
//   err_o is valid in RESP and is 0 elsewhere.
//  rdata_o updates when entering RESP for loads; stores leave it unchanged.
//  Max throughput: one access per READ_LAT+1 cycles.
//  Reset mid-operation: pending response dropped (no done_o); a store already committed stays.
//  req_i held high across RESP is accepted again only in the following IDLE cycle.
// TESTING
//  T1 READ_LAT=1,BE: store word 0x11223344 @0x10, load word @0x10 -> done_o at k+1, rdata_o=0x11223344; Mem[0x10]=0x11.
//  T2 store byte 0x80 @0x21; load byte signed @0x21 -> 0xFFFFFF80; load byte unsigned -> 0x00000080.
//  T3 store half 0x8001 @0x30; load half signed -> 0xFFFF8001; load half @0x31 -> err_o=1, rdata_o=0.
//  T4 word store @0x3FE (DEPTH 1024) -> err_o=1, Mem[0x3FC..0x3FF] unchanged; word @0x3FC -> ok.
//  T5 READ_LAT=3: accept at k -> ready_o=0 for k+1..k+3, done_o only at k+3; req ignored while busy.
//  T6 assert rst_i low in WAIT after a store -> no done_o, ready_o=1; a later load returns the stored value.

Source files
------------

// File: rtl/dmem_sized_port.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sized_port
// Brief    : Byte-addressable data memory with word/half/byte access behind a
//            req/done handshake, fixed response latency and error flagging.
// Revision : 1.0  initial release
// ============================================================================
module dmem_sized_port #(
    parameter int DEPTH_BYTES = 1024,
    parameter int READ_LAT    = 1,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);
    localparam int         c_AW        = $clog2(DEPTH_BYTES);
    localparam logic [1:0] c_WAIT_INIT = 2'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_cnt;
    logic [1:0]      w_cnt_nxt;

    logic [7:0]      r_mem [DEPTH_BYTES];

    logic            w_accept;
    logic [2:0]      w_nbytes;
    logic [1:0]      w_last_lane;
    logic            w_misalign;
    logic [32:0]     w_end_addr;
    logic            w_range_err;
    logic            w_err;
    logic [c_AW-1:0] w_idx [4];
    logic [1:0]      w_src [4];
    logic [7:0]      w_wbyte [4];
    logic [3:0]      w_lane_en;
    logic [31:0]     w_raw;
    logic [31:0]     w_load_val;

    logic            r_is_load;
    logic            r_err;
    logic [31:0]     r_hold;
    logic [31:0]     r_rdata;

    assign ready_o  = (r_state == S_IDLE);
    assign done_o   = (r_state == S_RESP);
    assign err_o    = done_o & r_err;
    assign rdata_o  = r_rdata;
    assign w_accept = req_i & ready_o & rst_i;

    always_comb begin
        w_nbytes    = 3'd1;
        w_last_lane = 2'd0;
        case (size_i)
            2'b11: begin
                w_nbytes    = 3'd4;
                w_last_lane = 2'd3;
            end
            2'b10: begin
                w_nbytes    = 3'd2;
                w_last_lane = 2'd1;
            end
            default: ;
        endcase
    end

    // The end address is computed with a carry bit so high addresses cannot wrap into range
    assign w_misalign  = (size_i == 2'b00)
                       | ((size_i == 2'b10) & addr_i[0])
                       | ((size_i == 2'b11) & (addr_i[1:0] != 2'b00));
    assign w_end_addr  = {1'b0, addr_i} + {30'd0, w_nbytes};
    assign w_range_err = (w_end_addr > 33'(DEPTH_BYTES));
    assign w_err       = w_misalign | w_range_err;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_idx[gi]     = addr_i[c_AW-1:0] + c_AW'(gi);
            assign w_lane_en[gi] = (2'(gi) <= w_last_lane);
            // w_src: which byte of the access slice lives at address offset gi
            assign w_src[gi]     = BIG_ENDIAN ? (w_last_lane - 2'(gi)) : 2'(gi);
            assign w_wbyte[gi]   = wdata_i[{w_src[gi], 3'b000} +: 8];
        end
    endgenerate

    always_comb begin
        w_raw = '0;
        for (int j = 0; j < 4; j++) begin
            if (w_lane_en[j]) begin
                w_raw[{w_src[j], 3'b000} +: 8] = r_mem[w_idx[j]];
            end
        end
    end

    always_comb begin
        case (size_i)
            2'b10:   w_load_val = {{16{w_raw[15] & ~unsigned_i}}, w_raw[15:0]};
            2'b01:   w_load_val = {{24{w_raw[7] & ~unsigned_i}}, w_raw[7:0]};
            default: w_load_val = w_raw;
        endcase
        if (w_err) begin
            w_load_val = '0;
        end
    end

    // Storage is deliberately outside the reset domain
    always_ff @(posedge clk_i) begin
        if (w_accept && we_i && !w_err) begin
            for (int j = 0; j < 4; j++) begin
                if (w_lane_en[j]) begin
                    r_mem[w_idx[j]] <= w_wbyte[j];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (READ_LAT == 1) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_is_load <= 1'b0;
            r_err     <= 1'b0;
            r_hold    <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_is_load <= ~we_i;
                r_err     <= w_err;
                r_hold    <= w_load_val;
            end
            // With single-cycle latency the response is entered straight from IDLE
            if ((r_state == S_IDLE) && (w_state_nxt == S_RESP) && !we_i) begin
                r_rdata <= w_load_val;
            end else if ((r_state == S_WAIT) && (w_state_nxt == S_RESP) && r_is_load) begin
                r_rdata <= r_hold;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_sized_port.sv
`default_nettype none
// Bench for dmem_sized_port: a READ_LAT=1 big-endian and a READ_LAT=3 little-endian
// instance share directed stimulus and are compared each cycle against a byte-array model.
module tb_dmem_sized_port;
    logic        clk_i      = 1'b0;
    logic        rst_i      = 1'b1;
    logic        req_i      = 1'b0;
    logic        we_i       = 1'b0;
    logic [1:0]  size_i     = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [31:0] addr_i     = '0;
    logic [31:0] wdata_i    = '0;

    logic        ready [2];
    logic        done  [2];
    logic        err   [2];
    logic [31:0] rdata [2];

    localparam logic [1:0] W = 2'b11, H = 2'b10, B = 2'b01, X = 2'b00;

    always #5 clk_i = ~clk_i;

    dmem_sized_port #(.DEPTH_BYTES(1024), .READ_LAT(1), .BIG_ENDIAN(1'b1)) u1 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ready_o(ready[0]), .done_o(done[0]), .err_o(err[0]), .rdata_o(rdata[0]));

    dmem_sized_port #(.DEPTH_BYTES(1024), .READ_LAT(3), .BIG_ENDIAN(1'b0)) u3 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ready_o(ready[1]), .done_o(done[1]), .err_o(err[1]), .rdata_o(rdata[1]));

    int          n_err = 0;
    int          n_chk = 0;
    int          lat [2] = '{1, 3};
    bit          be  [2] = '{1'b1, 1'b0};
    logic [7:0]  mm  [2][1024];
    int          t   [2] = '{0, 0};
    logic [31:0] exp_rdata [2] = '{32'd0, 32'd0};
    logic [31:0] pend_val  [2] = '{32'd0, 32'd0};
    bit          pend_err  [2] = '{1'b0, 1'b0};
    bit          pend_load [2] = '{1'b0, 1'b0};
    logic        last_err  [2] = '{1'b0, 1'b0};

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b11) ? 4 : (s == 2'b10) ? 2 : 1;
    endfunction

    function automatic bit access_err(input logic [1:0] s, input logic [31:0] a);
        int n = nbytes(s);
        if (s == 2'b00) return 1'b1;
        if ((a % n) != 0) return 1'b1;
        return (longint'(a) + longint'(n) > 64'sd1024);
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [1:0] s, input logic uns,
                                               input logic [31:0] a);
        int n = nbytes(s);
        int base = int'(a);
        logic [31:0] v = '0;
        for (int j = 0; j < n; j++) begin
            if (be[d]) v = (v << 8) | 32'(mm[d][base + j]);
            else       v = v | (32'(mm[d][base + j]) << (8 * j));
        end
        if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_accept(input int d);
        int n = nbytes(size_i);
        bit e = access_err(size_i, addr_i);
        pend_err[d]  = e;
        pend_load[d] = ~we_i;
        if (we_i) begin
            if (!e) begin
                for (int j = 0; j < n; j++) begin
                    if (be[d]) mm[d][int'(addr_i) + j] = 8'(wdata_i >> (8 * (n - 1 - j)));
                    else       mm[d][int'(addr_i) + j] = 8'(wdata_i >> (8 * j));
                end
            end
        end else begin
            pend_val[d] = e ? 32'd0 : model_load(d, size_i, unsigned_i, addr_i);
        end
    endtask

    // Reference model: t counts cycles since acceptance, 0 means idle
    always @(posedge clk_i) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_i) begin
                t[d]         = 0;
                exp_rdata[d] = '0;
            end else begin
                if (t[d] == 0) begin
                    if (req_i) begin
                        model_accept(d);
                        t[d] = 1;
                    end
                end else if (t[d] == lat[d]) begin
                    t[d] = 0;
                end else begin
                    t[d] = t[d] + 1;
                end
                if (t[d] == lat[d] && pend_load[d]) exp_rdata[d] = pend_val[d];
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            bit exp_done;
            exp_done = (t[d] != 0) && (t[d] == lat[d]);
            chk("ready", d, 32'(ready[d]), 32'(t[d] == 0));
            chk("done",  d, 32'(done[d]),  32'(exp_done));
            chk("err",   d, 32'(err[d]),   32'(exp_done && pend_err[d]));
            chk("rdata", d, rdata[d], exp_rdata[d]);
            if (done[d]) last_err[d] = err[d];
        end
    end

    // Called at a falling edge; returns at the falling edge where both instances are idle again
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
        @(negedge clk_i);
        req_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic lit_both(input string nm, input logic [31:0] rd, input logic e);
        for (int d = 0; d < 2; d++) begin
            chk({nm, " rdata"}, d, rdata[d], rd);
            chk({nm, " err"},   d, 32'(last_err[d]), 32'(e));
        end
    endtask

    task automatic lit_err(input string nm, input logic e);
        for (int d = 0; d < 2; d++) chk({nm, " err"}, d, 32'(last_err[d]), 32'(e));
    endtask

    initial begin
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        for (int d = 0; d < 2; d++) begin
            chk("reset ready", d, 32'(ready[d]), 32'd1);
            chk("reset done",  d, 32'(done[d]),  32'd0);
            chk("reset err",   d, 32'(err[d]),   32'd0);
            chk("reset rdata", d, rdata[d],      32'd0);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // T1: word round trip and byte placement
        xact(1'b1, W, 1'b0, 32'h10, 32'h1122_3344);
        lit_err("T1 store", 1'b0);
        chk("T1 mem[0x10] big", 0, 32'(u1.r_mem[16]), 32'h11);
        chk("T1 mem[0x10] little", 1, 32'(u3.r_mem[16]), 32'h44);
        xact(1'b0, W, 1'b0, 32'h10, 32'h0);
        lit_both("T1 load word", 32'h1122_3344, 1'b0);
        xact(1'b0, W, 1'b1, 32'h10, 32'h0);
        lit_both("T1 load word unsigned flag", 32'h1122_3344, 1'b0);

        // T2: byte store, signed and unsigned reload
        xact(1'b1, B, 1'b0, 32'h21, 32'h1234_5680);
        xact(1'b0, B, 1'b0, 32'h21, 32'h0);
        lit_both("T2 load byte signed", 32'hFFFF_FF80, 1'b0);
        xact(1'b0, B, 1'b1, 32'h21, 32'h0);
        lit_both("T2 load byte unsigned", 32'h0000_0080, 1'b0);

        // T3: half store, extension, misaligned half
        xact(1'b1, H, 1'b0, 32'h30, 32'hABCD_8001);
        xact(1'b0, H, 1'b0, 32'h30, 32'h0);
        lit_both("T3 load half signed", 32'hFFFF_8001, 1'b0);
        xact(1'b0, H, 1'b1, 32'h30, 32'h0);
        lit_both("T3 load half unsigned", 32'h0000_8001, 1'b0);
        xact(1'b0, H, 1'b0, 32'h31, 32'h0);
        lit_both("T3 load half misaligned", 32'h0, 1'b1);

        // T4: top-of-memory boundary and rejected stores
        xact(1'b1, W, 1'b0, 32'h3FC, 32'h5566_7788);
        lit_err("T4 store top word", 1'b0);
        xact(1'b1, W, 1'b0, 32'h3FE, 32'h9999_9999);
        lit_err("T4 store word 0x3FE", 1'b1);
        xact(1'b1, W, 1'b0, 32'hFFFF_FFFC, 32'hAAAA_AAAA);
        lit_err("T4 store word wrap", 1'b1);
        xact(1'b1, B, 1'b0, 32'h400, 32'h0000_00BB);
        lit_err("T4 store byte 0x400", 1'b1);
        xact(1'b1, X, 1'b0, 32'h3FC, 32'hCCCC_CCCC);
        lit_err("T4 store size 00", 1'b1);
        xact(1'b0, W, 1'b0, 32'h3FC, 32'h0);
        lit_both("T4 load top word", 32'h5566_7788, 1'b0);
        xact(1'b0, B, 1'b1, 32'h3FF, 32'h0);
        chk("T4 last byte big", 0, rdata[0], 32'h88);
        chk("T4 last byte little", 1, rdata[1], 32'h55);
        xact(1'b0, H, 1'b0, 32'h3FE, 32'h0);
        chk("T4 top half big", 0, rdata[0], 32'h7788);
        chk("T4 top half little", 1, rdata[1], 32'h5566);
        xact(1'b0, W, 1'b0, 32'h12, 32'h0);
        lit_both("T4 load word misaligned", 32'h0, 1'b1);

        // T5: request held high while the 3-cycle instance is busy
        xact(1'b1, W, 1'b0, 32'h200, 32'hA5A5_A5A5);
        req_i = 1'b1; we_i = 1'b0; size_i = W; unsigned_i = 1'b0; addr_i = 32'h200; wdata_i = '0;
        @(negedge clk_i);
        chk("T5 k+1 ready", 1, 32'(ready[1]), 32'd0);
        chk("T5 k+1 done",  1, 32'(done[1]),  32'd0);
        we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("T5 k+2 ready", 1, 32'(ready[1]), 32'd0);
        chk("T5 k+2 done",  1, 32'(done[1]),  32'd0);
        @(negedge clk_i);
        chk("T5 k+3 ready", 1, 32'(ready[1]), 32'd0);
        chk("T5 k+3 done",  1, 32'(done[1]),  32'd1);
        chk("T5 k+3 rdata", 1, rdata[1], 32'hA5A5_A5A5);
        req_i = 1'b0;
        @(negedge clk_i);
        chk("T5 k+4 ready", 1, 32'(ready[1]), 32'd1);
        xact(1'b0, W, 1'b0, 32'h200, 32'h0);
        chk("T5 reload lat1", 0, rdata[0], 32'hDEAD_BEEF);
        chk("T5 reload lat3", 1, rdata[1], 32'hA5A5_A5A5);

        // T6: reset while a store response is pending
        req_i = 1'b1; we_i = 1'b1; size_i = W; unsigned_i = 1'b0; addr_i = 32'h40; wdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        req_i = 1'b0;
        rst_i = 1'b0;
        #1;
        chk("T6 reset ready", 1, 32'(ready[1]), 32'd1);
        chk("T6 reset done",  1, 32'(done[1]),  32'd0);
        chk("T6 reset rdata", 1, rdata[1], 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (4) @(negedge clk_i);
        xact(1'b0, W, 1'b0, 32'h40, 32'h0);
        lit_both("T6 load after reset", 32'hCAFE_F00D, 1'b0);

        repeat (2) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
